cache_evict_fill_ctrl: RTL and testbench

Miss-handling controller for the 4-way set-associative L1 cache. It consumes the 2-bit victim way produced by the per-set pseudo-LRU tracker, writes back the victim line to physical memory if it is dirty, refills the line from memory, and then writes the new line into the chosen way. It also pulses the tracker's `update` input so the next victim rotates. It sits between the cache datapath/arrays and the physical-memory port.

---
 rtl/cache_evict_fill_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cache_evict_fill_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_evict_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_evict_fill_ctrl
// Purpose  : Miss-handling controller for a 4-way set-associative L1 cache.
//            Takes the victim way from the pseudo-LRU tracker, writes the
//            victim line back to physical memory when it is valid and dirty,
//            refills the line from memory, then writes it into the chosen way
//            and pulses the tracker update.
// Optional : EVICT_INVALID_FIRST_EN -- when defined, the lowest-numbered
//            invalid way is filled in preference to the LRU victim, and the
//            tracker is only updated when the LRU victim was actually used.
// Ports    :
//   clk, rst_n          clock, asynchronous active-low reset
//   i_miss_req/addr     level miss request and missing address
//   i_way_valid/dirty   valid/dirty bits of the addressed set
//   i_victim_way/tag/data  LRU victim and its stored tag/line
//   o_pmem_read/write   memory strobes, held until i_pmem_resp
//   o_pmem_address      line address ([3:0] always zero)
//   o_pmem_wdata        writeback line
//   i_pmem_rdata/resp   refill line and single-cycle completion pulse
//   o_fill_we/index/tag/data  one-cycle array write of the new line
//   o_lru_update        one-cycle pulse to the tracker
//   o_miss_done         one-cycle completion pulse
//   o_busy              high whenever the controller is not idle
// Revision : 1.0 - initial release
// ============================================================================
module cache_evict_fill_ctrl #(
   parameter int TAG_W  = 9,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_miss_req,
   input  logic [15:0]       i_miss_addr,
   input  logic [3:0]        i_way_valid,
   input  logic [3:0]        i_way_dirty,
   input  logic [1:0]        i_victim_way,
   input  logic [TAG_W-1:0]  i_victim_tag,
   input  logic [LINE_W-1:0] i_victim_data,
   output logic              o_pmem_read,
   output logic              o_pmem_write,
   output logic [15:0]       o_pmem_address,
   output logic [LINE_W-1:0] o_pmem_wdata,
   input  logic [LINE_W-1:0] i_pmem_rdata,
   input  logic              i_pmem_resp,
   output logic [3:0]        o_fill_we,
   output logic [2:0]        o_fill_index,
   output logic [TAG_W-1:0]  o_fill_tag,
   output logic [LINE_W-1:0] o_fill_data,
   output logic              o_lru_update,
   output logic              o_miss_done,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_FILL      = 2'd2,
      ST_COMMIT    = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [TAG_W-1:0]    r_miss_tag;
   logic [2:0]          r_index;
   logic [1:0]          r_way;
   logic                r_from_lru;
   logic [TAG_W-1:0]    r_victim_tag;
   logic [LINE_W-1:0]   r_victim_data;
   logic [LINE_W-1:0]   r_line;

   logic [1:0]          w_tgt_way;
   logic                w_tgt_from_lru;
   logic                w_tgt_needs_wb;
   logic                w_accept;

   // Target way selection. The descending loop lets the lowest invalid way
   // win when the invalid-first policy is compiled in.
   always_comb begin
      w_tgt_way      = i_victim_way;
      w_tgt_from_lru = 1'b1;
`ifdef EVICT_INVALID_FIRST_EN
      for (int i = 3; i >= 0; i--) begin
         if (!i_way_valid[i]) begin
            w_tgt_way      = 2'(i);
            w_tgt_from_lru = 1'b0;
         end
      end
`else
`endif
   end

   assign w_tgt_needs_wb = i_way_valid[w_tgt_way] & i_way_dirty[w_tgt_way];
   assign w_accept       = (r_state == ST_IDLE) && i_miss_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Request and victim context is captured at accept so later changes on the
   // array read port cannot corrupt an in-flight writeback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_miss_tag    <= '0;
         r_index       <= '0;
         r_way         <= '0;
         r_from_lru    <= 1'b0;
         r_victim_tag  <= '0;
         r_victim_data <= '0;
         r_line        <= '0;
      end else begin
         if (w_accept) begin
            r_miss_tag    <= i_miss_addr[15 -: TAG_W];
            r_index       <= i_miss_addr[6:4];
            r_way         <= w_tgt_way;
            r_from_lru    <= w_tgt_from_lru;
            r_victim_tag  <= i_victim_tag;
            r_victim_data <= i_victim_data;
         end
         if ((r_state == ST_FILL) && i_pmem_resp) begin
            r_line <= i_pmem_rdata;
         end
      end
   end

   // Next state and Moore outputs, decoded only from registered state.
   always_comb begin
      w_state_nxt    = r_state;
      o_pmem_read    = 1'b0;
      o_pmem_write   = 1'b0;
      o_pmem_address = '0;
      o_pmem_wdata   = '0;
      o_fill_we      = 4'b0000;
      o_fill_index   = '0;
      o_fill_tag     = '0;
      o_fill_data    = '0;
      o_lru_update   = 1'b0;
      o_miss_done    = 1'b0;
      o_busy         = (r_state != ST_IDLE);

      case (r_state)
         ST_IDLE: begin
            if (i_miss_req) begin
               w_state_nxt = w_tgt_needs_wb ? ST_WRITEBACK : ST_FILL;
            end
         end
         ST_WRITEBACK: begin
            o_pmem_write   = 1'b1;
            o_pmem_address = {r_victim_tag, r_index, 4'b0000};
            o_pmem_wdata   = r_victim_data;
            if (i_pmem_resp) begin
               w_state_nxt = ST_FILL;
            end
         end
         ST_FILL: begin
            o_pmem_read    = 1'b1;
            o_pmem_address = {r_miss_tag, r_index, 4'b0000};
            if (i_pmem_resp) begin
               w_state_nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            o_fill_we    = 4'b0001 << r_way;
            o_fill_index = r_index;
            o_fill_tag   = r_miss_tag;
            o_fill_data  = r_line;
            o_miss_done  = 1'b1;
            o_lru_update = r_from_lru;
            w_state_nxt  = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_evict_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_evict_fill_ctrl
// Purpose  : Self-checking bench for cache_evict_fill_ctrl. Table vectors,
//            hand-written reset / stale-response / back-to-back sequences,
//            and randomized misses checked against a behavioural model.
//            Expectations follow EVICT_INVALID_FIRST_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_evict_fill_ctrl;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_miss_req;
   logic [15:0]   i_miss_addr;
   logic [3:0]    i_way_valid;
   logic [3:0]    i_way_dirty;
   logic [1:0]    i_victim_way;
   logic [8:0]    i_victim_tag;
   logic [127:0]  i_victim_data;
   logic          o_pmem_read;
   logic          o_pmem_write;
   logic [15:0]   o_pmem_address;
   logic [127:0]  o_pmem_wdata;
   logic [127:0]  i_pmem_rdata;
   logic          i_pmem_resp;
   logic [3:0]    o_fill_we;
   logic [2:0]    o_fill_index;
   logic [8:0]    o_fill_tag;
   logic [127:0]  o_fill_data;
   logic          o_lru_update;
   logic          o_miss_done;
   logic          o_busy;

   int checks   = 0;
   int failures = 0;

   cache_evict_fill_ctrl #(.TAG_W(9), .LINE_W(128)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_miss_req     (i_miss_req),
      .i_miss_addr    (i_miss_addr),
      .i_way_valid    (i_way_valid),
      .i_way_dirty    (i_way_dirty),
      .i_victim_way   (i_victim_way),
      .i_victim_tag   (i_victim_tag),
      .i_victim_data  (i_victim_data),
      .o_pmem_read    (o_pmem_read),
      .o_pmem_write   (o_pmem_write),
      .o_pmem_address (o_pmem_address),
      .o_pmem_wdata   (o_pmem_wdata),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .o_fill_we      (o_fill_we),
      .o_fill_index   (o_fill_index),
      .o_fill_tag     (o_fill_tag),
      .o_fill_data    (o_fill_data),
      .o_lru_update   (o_lru_update),
      .o_miss_done    (o_miss_done),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [3:0]  valid;
      logic [3:0]  dirty;
      logic [1:0]  vway;
      logic [8:0]  vtag;
      int          wbw;
      int          rdw;
      logic [3:0]  exp_we;
      bit          exp_wb;
      bit          exp_lru;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Replacement policy stated directly: prefer the first empty way when the
   // option is on, otherwise (or if the set is full) take the LRU victim.
   function automatic void model(input logic [3:0] valid, input logic [3:0] dirty,
                                 input logic [1:0] vway, output logic [3:0] we,
                                 output bit wb, output bit lru);
      int way;
      way = int'(vway);
      lru = 1'b1;
`ifdef EVICT_INVALID_FIRST_EN
      for (int i = 0; i < 4; i++) begin
         if (!valid[i] && lru) begin
            way = i;
            lru = 1'b0;
         end
      end
`endif
      wb = valid[way] && dirty[way];
      we = 4'(1 << way);
   endfunction

   // Drives one miss from the current (IDLE) cycle to completion and checks
   // every cycle. With hold set, the request stays high past miss_done.
   task automatic run_miss(input logic [15:0] addr, input logic [3:0] valid,
                           input logic [3:0] dirty, input logic [1:0] vway,
                           input logic [8:0] vtag, input int wbw, input int rdw,
                           input logic [3:0] exp_we, input bit exp_wb,
                           input bit exp_lru, input bit hold);
      logic [127:0] vdata;
      logic [127:0] rdata;
      vdata = rnd_line();
      rdata = rnd_line();
      i_miss_addr   = addr;
      i_way_valid   = valid;
      i_way_dirty   = dirty;
      i_victim_way  = vway;
      i_victim_tag  = vtag;
      i_victim_data = vdata;
      i_miss_req    = 1'b1;
      tick();
      chk("busy_after_accept", 128'(o_busy), 128'(1'b1));
      // Array read port moves on; the controller must use its captured copy.
      i_victim_tag  = ~vtag;
      i_victim_data = ~vdata;
      i_way_valid   = ~valid;
      i_way_dirty   = ~dirty;
      i_victim_way  = ~vway;
      if (exp_wb) begin
         for (int k = 0; k <= wbw; k++) begin
            chk("wb_write", 128'(o_pmem_write), 128'(1'b1));
            chk("wb_read", 128'(o_pmem_read), 128'(1'b0));
            chk("wb_addr", 128'(o_pmem_address), 128'({vtag, addr[6:4], 4'h0}));
            chk("wb_wdata", o_pmem_wdata, vdata);
            i_pmem_resp = (k == wbw);
            tick();
         end
         i_pmem_resp = 1'b0;
      end
      for (int k = 0; k <= rdw; k++) begin
         chk("fill_read", 128'(o_pmem_read), 128'(1'b1));
         chk("fill_write", 128'(o_pmem_write), 128'(1'b0));
         chk("fill_addr", 128'(o_pmem_address), 128'({addr[15:4], 4'h0}));
         chk("fill_no_done", 128'(o_miss_done), 128'(1'b0));
         i_pmem_resp  = (k == rdw);
         i_pmem_rdata = (k == rdw) ? rdata : ~rdata;
         tick();
      end
      i_pmem_resp  = 1'b0;
      i_pmem_rdata = ~rdata;
      chk("commit_we", 128'(o_fill_we), 128'(exp_we));
      chk("commit_index", 128'(o_fill_index), 128'(addr[6:4]));
      chk("commit_tag", 128'(o_fill_tag), 128'(addr[15:7]));
      chk("commit_data", o_fill_data, rdata);
      chk("commit_done", 128'(o_miss_done), 128'(1'b1));
      chk("commit_lru", 128'(o_lru_update), 128'(exp_lru));
      chk("commit_strobes", 128'({o_pmem_read, o_pmem_write}), 128'(2'b00));
      if (!hold) i_miss_req = 1'b0;
      tick();
      chk("idle_busy", 128'(o_busy), 128'(1'b0));
      chk("idle_done", 128'(o_miss_done), 128'(1'b0));
      chk("idle_we", 128'(o_fill_we), 128'(4'b0000));
   endtask

   initial begin
      logic [3:0]  m_we;
      bit          m_wb;
      bit          m_lru;
      logic [127:0] d;

`ifdef EVICT_INVALID_FIRST_EN
      tbl[0] = '{16'h1230, 4'b1111, 4'b0000, 2'd2, 9'h1A0, 0, 3, 4'b0100, 1'b0, 1'b1};
      tbl[1] = '{16'h4A70, 4'b1111, 4'b0010, 2'd1, 9'h055, 2, 1, 4'b0010, 1'b1, 1'b1};
      tbl[2] = '{16'h2350, 4'b1011, 4'b0000, 2'd0, 9'h0AA, 0, 0, 4'b0100, 1'b0, 1'b0};
      tbl[3] = '{16'hFFF0, 4'b1011, 4'b0001, 2'd0, 9'h123, 1, 0, 4'b0100, 1'b0, 1'b0};
      tbl[4] = '{16'h0010, 4'b0000, 4'b1111, 2'd3, 9'h0F0, 0, 2, 4'b0001, 1'b0, 1'b0};
      tbl[5] = '{16'h8000, 4'b1111, 4'b1111, 2'd3, 9'h1FF, 0, 0, 4'b1000, 1'b1, 1'b1};
`else
      tbl[0] = '{16'h1230, 4'b1111, 4'b0000, 2'd2, 9'h1A0, 0, 3, 4'b0100, 1'b0, 1'b1};
      tbl[1] = '{16'h4A70, 4'b1111, 4'b0010, 2'd1, 9'h055, 2, 1, 4'b0010, 1'b1, 1'b1};
      tbl[2] = '{16'h2350, 4'b1011, 4'b0000, 2'd0, 9'h0AA, 0, 0, 4'b0001, 1'b0, 1'b1};
      tbl[3] = '{16'hFFF0, 4'b1011, 4'b0001, 2'd0, 9'h123, 1, 0, 4'b0001, 1'b1, 1'b1};
      tbl[4] = '{16'h0010, 4'b0000, 4'b1111, 2'd3, 9'h0F0, 0, 2, 4'b1000, 1'b0, 1'b1};
      tbl[5] = '{16'h8000, 4'b1111, 4'b1111, 2'd3, 9'h1FF, 0, 0, 4'b1000, 1'b1, 1'b1};
`endif

      rst_n         = 1'b0;
      i_miss_req    = 1'b0;
      i_miss_addr   = '0;
      i_way_valid   = '0;
      i_way_dirty   = '0;
      i_victim_way  = '0;
      i_victim_tag  = '0;
      i_victim_data = '0;
      i_pmem_rdata  = '0;
      i_pmem_resp   = 1'b0;

      // Reset state
      tick();
      chk("rst_busy", 128'(o_busy), 128'(1'b0));
      chk("rst_strobes", 128'({o_pmem_read, o_pmem_write}), 128'(2'b00));
      chk("rst_addr", 128'(o_pmem_address), 128'(16'h0));
      chk("rst_wdata", o_pmem_wdata, 128'(0));
      chk("rst_fill", 128'({o_fill_we, o_fill_index, o_fill_tag}), 128'(0));
      chk("rst_fill_data", o_fill_data, 128'(0));
      chk("rst_pulses", 128'({o_lru_update, o_miss_done}), 128'(2'b00));
      tick();
      rst_n = 1'b1;
      tick();

      // Table vectors
      for (int v = 0; v < 6; v++) begin
         run_miss(tbl[v].addr, tbl[v].valid, tbl[v].dirty, tbl[v].vway, tbl[v].vtag,
                  tbl[v].wbw, tbl[v].rdw, tbl[v].exp_we, tbl[v].exp_wb, tbl[v].exp_lru, 1'b0);
      end

      // Stale pmem_resp in IDLE must be ignored
      i_pmem_resp = 1'b1;
      tick();
      i_pmem_resp = 1'b0;
      chk("stale_busy", 128'(o_busy), 128'(1'b0));
      chk("stale_strobes", 128'({o_pmem_read, o_pmem_write}), 128'(2'b00));
      tick();
      chk("stale_busy2", 128'(o_busy), 128'(1'b0));

      // Back-to-back: request held one cycle past miss_done is a new miss
      model(4'b1111, 4'b0000, 2'd2, m_we, m_wb, m_lru);
      run_miss(16'h3C50, 4'b1111, 4'b0000, 2'd2, 9'h011, 0, 0, m_we, m_wb, m_lru, 1'b1);
      model(4'b1111, 4'b1000, 2'd3, m_we, m_wb, m_lru);
      run_miss(16'h5DA0, 4'b1111, 4'b1000, 2'd3, 9'h0C3, 1, 1, m_we, m_wb, m_lru, 1'b0);

      // Reset two cycles into a writeback
      d = rnd_line();
      i_miss_addr   = 16'h7770;
      i_way_valid   = 4'b1111;
      i_way_dirty   = 4'b1111;
      i_victim_way  = 2'd0;
      i_victim_tag  = 9'h1AB;
      i_victim_data = d;
      i_miss_req    = 1'b1;
      tick();
      chk("rstwb_write", 128'(o_pmem_write), 128'(1'b1));
      tick();
      chk("rstwb_write2", 128'(o_pmem_write), 128'(1'b1));
      rst_n      = 1'b0;
      i_miss_req = 1'b0;
      #1;
      chk("rstwb_async_write", 128'(o_pmem_write), 128'(1'b0));
      chk("rstwb_async_busy", 128'(o_busy), 128'(1'b0));
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rstwb_hold_we", 128'({o_fill_we, o_miss_done}), 128'(0));
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rstwb_after_busy", 128'(o_busy), 128'(1'b0));
         chk("rstwb_after_we", 128'({o_fill_we, o_miss_done}), 128'(0));
      end

      // Randomized misses against the model
      for (int n = 0; n < 40; n++) begin
         logic [15:0] a;
         logic [3:0]  vv;
         logic [3:0]  dd;
         logic [1:0]  w;
         a  = 16'($urandom) & 16'hFFF0;
         vv = 4'($urandom);
         dd = 4'($urandom);
         w  = 2'($urandom);
         model(vv, dd, w, m_we, m_wb, m_lru);
         run_miss(a, vv, dd, w, 9'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), m_we, m_wb, m_lru, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
